// File: rtl/riscv_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between execute (port 0) and aux unit (port 1).
// One op in flight: accept at T, ALU driven T+1..T+ALU_LAT, response held from T+ALU_LAT+1 until taken.
`ifndef ALUOP_NOP
`define ALUOP_NOP  4'd0
`define ALUOP_ADD  4'd1
`define ALUOP_SUB  4'd2
`define ALUOP_SLL  4'd3
`define ALUOP_SLT  4'd4
`define ALUOP_SLTU 4'd5
`define ALUOP_XOR  4'd6
`define ALUOP_SRL  4'd7
`define ALUOP_SRA  4'd8
`define ALUOP_OR   4'd9
`define ALUOP_AND  4'd10
`endif

module riscv_alu_arbiter #(
  parameter int DW      = 32,
  parameter int CW      = 4,
  parameter int ALU_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [CW-1:0] req0_ctl_i,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  output logic          rsp0_valid_o,
  input  logic          rsp0_ready_i,
  output logic [DW-1:0] rsp0_data_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [CW-1:0] req1_ctl_i,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  output logic          rsp1_valid_o,
  input  logic          rsp1_ready_i,
  output logic [DW-1:0] rsp1_data_o,
  output logic [CW-1:0] alu_ctl_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  input  logic [DW-1:0] alu_result_i,
  output logic          busy_o,
  output logic          grant_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [CW-1:0] ALU_NOP  = CW'(`ALUOP_NOP);
  localparam logic [3:0]    CNT_INIT = 4'(ALU_LAT - 1);

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          grant_q, grant_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [CW-1:0] ctl_q, ctl_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          rdy0, rdy1;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    case (state_q)
      IDLE: begin
        // The prio holder wins a tie; a lone requester always wins.
        rdy0 = req0_valid_i && (!req1_valid_i || !prio_q);
        rdy1 = req1_valid_i && (!req0_valid_i ||  prio_q);
        if (rdy0) begin
          ctl_d   = req0_ctl_i;
          a_d     = req0_a_i;
          b_d     = req0_b_i;
          grant_d = 1'b0;
          prio_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end else if (rdy1) begin
          ctl_d   = req1_ctl_i;
          a_d     = req1_a_i;
          b_d     = req1_b_i;
          grant_d = 1'b1;
          prio_d  = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_result_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (grant_q ? rsp1_ready_i : rsp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= 4'd0;
      ctl_q   <= ALU_NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Ready is masked during reset so no handshake is seen before state settles.
  assign req0_ready_o = rdy0 && !rst_i;
  assign req1_ready_o = rdy1 && !rst_i;

  assign alu_ctl_o    = (state_q == EXEC) ? ctl_q : ALU_NOP;
  assign alu_a_o      = (state_q == EXEC) ? a_q   : '0;
  assign alu_b_o      = (state_q == EXEC) ? b_q   : '0;

  assign rsp0_valid_o = (state_q == RESP) && !grant_q;
  assign rsp1_valid_o = (state_q == RESP) &&  grant_q;
  assign rsp0_data_o  = rsp0_valid_o ? res_q : '0;
  assign rsp1_data_o  = rsp1_valid_o ? res_q : '0;

  assign busy_o  = (state_q != IDLE);
  assign grant_o = grant_q;

endmodule

// File: doc/riscv_alu_arbiter.md
Name: riscv_alu_arbiter

Overview:
- Shares the single core ALU between two requesters: port 0 is the execute stage, port 1 is the auxiliary/multi-cycle unit.
- Accepts one operation at a time over a valid/ready handshake and chooses between simultaneous requests round-robin.
- Drives the ALU control code and operands for a parameterised number of cycles, then captures the result.
- Returns the result to the winning requester over a valid/ready response handshake.

Parameters:
- DW, 32, operand/result width.
- CW, 4, ALU control code width; matches the `aluop_* encodings in define.h.
- ALU_LAT, 1, cycles the ALU needs from stable operands to a valid result; legal range 1..15.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- req0_valid_i  in  1  port 0 request valid.
- req0_ready_o  out  1  port 0 request accepted this cycle.
- req0_ctl_i  in  CW  port 0 ALU control code.
- req0_a_i  in  DW  port 0 operand A.
- req0_b_i  in  DW  port 0 operand B.
- rsp0_valid_o  out  1  port 0 result valid.
- rsp0_ready_i  in  1  port 0 result taken.
- rsp0_data_o  out  DW  port 0 result.
- req1_valid_i, req1_ready_o, req1_ctl_i, req1_a_i, req1_b_i, rsp1_valid_o, rsp1_ready_i, rsp1_data_o: same as port 0, for port 1.
- alu_ctl_o  out  CW  control code to the ALU.
- alu_a_o  out  DW  ALU operand A.
- alu_b_o  out  DW  ALU operand B.
- alu_result_i  in  DW  ALU result.
- busy_o  out  1  operation in flight.
- grant_o  out  1  id of the last accepted requester.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i); all state updates on the rising edge of clk_i.
- Reset values: state IDLE, round-robin pointer prio=0, grant_o=0, busy_o=0, rsp0/1_valid_o=0, rsp0/1_data_o=0, alu_ctl_o=`aluop_nop, alu_a_o=0, alu_b_o=0.
- req*_ready_o is combinational. Both ready outputs are 0 while the arbiter is not idle.
- Exactly one of the ready outputs can be 1 in a cycle.
- States:
  - IDLE:
    - reqk_ready_o = reqk_valid_i && (!req(other)_valid_i || prio==k).
    - On a handshake to port k: latch ctl/a/b, set grant_o=k, set prio=!k, load cnt=ALU_LAT-1, go to EXEC.
    - No valid input: stay in IDLE.
  - EXEC:
    - alu_ctl_o/alu_a_o/alu_b_o are driven from the latched registers and held stable for all ALU_LAT cycles.
    - If cnt==0: register alu_result_i into the result register and go to RESP. Otherwise cnt decrements.
  - RESP:
    - rsp(grant)_valid_o=1 and rsp(grant)_data_o = captured result; the other port's rsp_valid_o=0 and rsp_data_o=0.
    - On rsp(grant)_ready_i=1, go to IDLE and drop valid the next cycle.
    - rsp_valid_o is held with stable data while ready is low (indefinite backpressure allowed).
- Outside EXEC: alu_ctl_o=`aluop_nop and the operands are 0.
- busy_o = (state != IDLE).
- Latency:
  - Handshake cycle = T.
  - EXEC occupies T+1..T+ALU_LAT.
  - rsp_valid_o is first high at T+ALU_LAT+1.
  - Next accept is possible no earlier than the cycle after the response handshake.
  - Minimum issue interval is ALU_LAT+2 cycles.
- Requesters hold ctl/a/b stable while valid is high and ready is low. Dropping valid before the handshake is allowed and no request is recorded.
- Any control code, including `aluop_nop, is forwarded unmodified; the arbiter does no decoding.
- Simultaneous requests: the winner is prio. Under continuous contention the two ports alternate strictly (0,1,0,1...).
- A single requester is always served immediately, but the pointer still toggles after each grant.
- Reset mid-operation (EXEC or RESP):
  - The operation is discarded and no response is issued.
  - All outputs return to their reset values on the next cycle.

Test Plan:
- Reset: assert rst_i for 2 cycles with both valids high -> both ready=0 during reset; after release busy_o=0, alu_ctl_o=`aluop_nop, rsp*_valid_o=0; port 0 is granted first.
- Single op, ALU_LAT=1: port 0 requests ADD a=5, b=7 at cycle T -> req0_ready_o=1 at T; alu_ctl_o=`aluop_add, alu_a_o=5, alu_b_o=7 at T+1; rsp0_valid_o=1 with rsp0_data_o=12 at T+2; rsp1_valid_o stays 0.
- Contention: both ports hold valid (port 0 OR 0xF0|0x0F, port 1 ADD 1+1) for 4 operations -> grants in order 0,1,0,1; each response on the correct port (0xFF and 2 respectively).
- Backpressure: hold rsp1_ready_i=0 for 5 cycles -> rsp1_valid_o and data stable, busy_o=1, both req ready=0; release -> back to IDLE next cycle.
- ALU_LAT=3: port 1 SRA a=0x80000000, b=4 -> ALU outputs stable for 3 cycles; response 0xF8000000 at T+4.
- Reset in EXEC: assert rst_i during the second EXEC cycle -> no rsp valid ever appears; pointer back to 0; the next simultaneous request is granted to port 0.
